// File: rtl/sid_pkg.sv
// Shared constants and types for the SID filter scheduler: the filter step
// numbering, the pass length and the sequencer state encoding.
package sid_pkg;

  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] LP      = 3'd3;
  localparam logic [2:0] BP      = 3'd4;
  localparam logic [2:0] HPVOL   = 3'd5;
  localparam logic [2:0] CAPTURE = 3'd6;

  localparam int PASS_LEN = 8;

  // ST_PEND means "running, with one more tick queued behind this run".
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic        mode;
    logic [15:0] f0;
    logic [7:0]  res_filt;
    logic [7:0]  mode_vol;
  } chip_cfg_t;

  // A silenced pass keeps chip 0's model so the filter's coefficients stay sane.
  function automatic chip_cfg_t mute_cfg(input chip_cfg_t c, input logic model0);
    chip_cfg_t m;
    m          = c;
    m.mode     = model0;
    m.res_filt = 8'h00;
    m.mode_vol = 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/sid_filter_sched.sv
// Time-multiplexes one SID filter between two chips: each sample tick runs a
// chip-0 pass and then a chip-1 pass of PASS_LEN filter steps each.
import sid_pkg::*;

module sid_filter_sched #(
  parameter bit         DUAL       = 1'b1,
  parameter logic [2:0] IDLE_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [15:0] F0_0,
  input  logic [15:0] F0_1,
  input  logic [7:0]  Res_Filt_0,
  input  logic [7:0]  Res_Filt_1,
  input  logic [7:0]  Mode_Vol_0,
  input  logic [7:0]  Mode_Vol_1,
  input  logic [17:0] f_audio,
  output logic [2:0]  f_state,
  output logic        f_mode,
  output logic [15:0] f_F0,
  output logic [7:0]  f_Res_Filt,
  output logic [7:0]  f_Mode_Vol,
  output logic        chip,
  output logic [17:0] audio_l,
  output logic [17:0] audio_r,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [3:0] LAST_STEP = 4'(2 * PASS_LEN - 1);

  sched_state_t state_reg, state_next;
  logic [3:0]   k_reg, k_next;
  logic         overrun_reg;
  logic         sample_valid_reg;
  logic [17:0]  audio_l_reg, audio_r_reg;
  chip_cfg_t    shadow_reg [2];
  chip_cfg_t    cfg_raw    [2];
  chip_cfg_t    cfg_snap   [2];
  chip_cfg_t    cfg_cur;

  logic running, last_step, start, overrun_set;

  assign cfg_raw[0] = '{mode: mode0, f0: F0_0, res_filt: Res_Filt_0, mode_vol: Mode_Vol_0};
  assign cfg_raw[1] = '{mode: mode1, f0: F0_1, res_filt: Res_Filt_1, mode_vol: Mode_Vol_1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_snap
      if (gi == 1 && !DUAL) begin : gen_muted
        assign cfg_snap[gi] = mute_cfg(cfg_raw[gi], mode0);
      end else begin : gen_live
        assign cfg_snap[gi] = cfg_raw[gi];
      end
    end
  endgenerate

  assign running     = (state_reg != ST_IDLE);
  assign last_step   = running && (k_reg == LAST_STEP);
  // A run begins from idle, or back-to-back when the previous run ends.
  assign start       = ((state_reg == ST_IDLE) && ce_1m) ||
                       (last_step && ((state_reg == ST_PEND) || ce_1m));
  assign overrun_set = ce_1m && (state_reg == ST_PEND);
  assign k_next      = running ? k_reg + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      k_reg     <= 4'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ce_1m) state_next = ST_RUN;
      ST_RUN: begin
        if (last_step)  state_next = ce_1m ? ST_RUN : ST_IDLE;
        else if (ce_1m) state_next = ST_PEND;
      end
      ST_PEND: if (last_step) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // Idle selects chip 1's shadow, which is exactly what the last pass drove.
  always_comb begin
    cfg_cur    = shadow_reg[running ? k_reg[3] : 1'b1];
    f_state    = running ? k_reg[2:0] : IDLE_STATE;
    chip       = running & k_reg[3];
    busy       = running;
    f_mode     = cfg_cur.mode;
    f_F0       = cfg_cur.f0;
    f_Res_Filt = cfg_cur.res_filt;
    f_Mode_Vol = cfg_cur.mode_vol;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_reg[0]    <= '0;
      shadow_reg[1]    <= '0;
      audio_l_reg      <= '0;
      audio_r_reg      <= '0;
      sample_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      if (start) shadow_reg <= cfg_snap;
      if (running && k_reg == {1'b0, CAPTURE}) audio_l_reg <= f_audio;
      if (running && k_reg == {1'b1, CAPTURE}) audio_r_reg <= DUAL ? f_audio : audio_l_reg;
      sample_valid_reg <= last_step;
      overrun_reg      <= overrun_reg | overrun_set;
    end
  end

  assign audio_l      = audio_l_reg;
  assign audio_r      = audio_r_reg;
  assign sample_valid = sample_valid_reg;
  assign overrun      = overrun_reg;

endmodule
